// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants, FSM state encoding and opcode helpers for mem_access
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) ||
           (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - big-endian byte-enable/store-data generation and load extract/extend
module mem_byte_lane
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  ofs,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  // Lane ofs=0 is the most significant byte.
  always_comb begin
    ld_byte = ld_raw[31:24];
    case (ofs)
      2'd1:    ld_byte = ld_raw[23:16];
      2'd2:    ld_byte = ld_raw[15:8];
      2'd3:    ld_byte = ld_raw[7:0];
      default: ld_byte = ld_raw[31:24];
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = ld_raw;
    case (opcode)
      OP_LB: begin
        be      = 4'b1000 >> ofs;
        ld_data = {{24{ld_byte[7]}}, ld_byte};
      end
      OP_LBU: begin
        be      = 4'b1000 >> ofs;
        ld_data = {24'h000000, ld_byte};
      end
      OP_SB: begin
        be    = 4'b1000 >> ofs;
        wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: LW/SW/LB/LBU/SB over req/ack, pass-through otherwise
// Optional MEM_MISALIGN_TRAP_EN: misaligned LW/SW pulse misalign instead of issuing a request.
module mem_access
  import mips_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_mem,
  input  logic [31:0]       insn,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       rtData,
  output logic              busy,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       wbData,
  output logic              wbValid,
  output logic              misalign
);

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        ofs_q, ofs_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;

  logic [5:0]  opcode;
  logic [1:0]  ofs_in;
  logic [5:0]  lane_op;
  logic [1:0]  lane_ofs;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;
  logic        trap;
  logic        unused_insn;

  assign opcode      = insn[31:26];
  assign ofs_in      = aluResult[1:0];
  assign unused_insn = ^insn[25:0];

  // While in REQ the lane decodes the latched load so rdata formatting follows the accepted insn.
  assign lane_op  = (state_q == REQ) ? op_q  : opcode;
  assign lane_ofs = (state_q == REQ) ? ofs_q : ofs_in;

  mem_byte_lane u_lane (
    .opcode  (lane_op),
    .ofs     (lane_ofs),
    .st_data (rtData),
    .ld_raw  (dmem_rdata),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .ld_data (lane_ld)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_word(opcode) && (ofs_in != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ofs_d      = ofs_q;
    busy_d     = busy_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      REQ: begin
        if (dmem_ack) begin
          state_d = RESP;
          busy_d  = 1'b0;
          req_d   = 1'b0;
          if (!is_store(op_q)) begin
            wb_data_d  = lane_ld;
            wb_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and RESP both accept a new operation.
        state_d = IDLE;
        if (enable_mem) begin
          if (is_mem_op(opcode)) begin
            if (trap) begin
              misalign_d = 1'b1;
            end else begin
              state_d = REQ;
              busy_d  = 1'b1;
              req_d   = 1'b1;
              we_d    = is_store(opcode);
              addr_d  = aluResult[ADDR_W+1:2];
              be_d    = lane_be;
              wdata_d = lane_wdata;
              op_d    = opcode;
              ofs_d   = ofs_in;
            end
          end else begin
            wb_data_d  = aluResult;
            wb_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      ofs_q      <= '0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ofs_q      <= ofs_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign busy       = busy_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wbData     = wb_data_q;
  assign wbValid    = wb_valid_q;
  assign misalign   = misalign_q;

endmodule
